// File: rtl/axi_pkg.sv
// Shared AXI4 types and helpers for the read-side engines.
// Beat-address stepping and burst-legality checks live here.
package axi_pkg;

    typedef enum logic [2:0] {
        SIZE_1   = 3'd0,
        SIZE_2   = 3'd1,
        SIZE_4   = 3'd2,
        SIZE_8   = 3'd3,
        SIZE_16  = 3'd4,
        SIZE_32  = 3'd5,
        SIZE_64  = 3'd6,
        SIZE_128 = 3'd7
    } AxiSize_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } AxiBurst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } AxiResp_t;

    localparam int AXI_ID_MAX = 16;

    typedef struct packed {
        logic [AXI_ID_MAX-1:0] id;
        logic [31:0]           addr;
        logic [7:0]            len;
        AxiSize_t              size;
        AxiBurst_t             burst;
    } AxiAr_t;

    function automatic logic axiWrapLenLegal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [31:0] axiNextAddr(
        input logic [31:0] addr,
        input AxiSize_t    size,
        input AxiBurst_t   burst,
        input logic [7:0]  len
    );
        logic [31:0] s;
        logic [31:0] w;
        logic [31:0] nxt;
        s   = 32'd1 << size;
        w   = (32'(len) + 32'd1) * s;
        nxt = addr;
        case (burst)
            BURST_INCR: nxt = (addr & ~(s - 32'd1)) + s;
            BURST_WRAP: nxt = (addr & ~(w - 32'd1)) |
                              ((addr + s) & (w - 32'd1));
            default:    nxt = addr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi_rd_buf.sv
// Two-entry synchronous FIFO holding R beats that the master
// has not yet taken; exposes its occupancy for issue pacing.
module axi_rd_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read subordinate: one burst at a time, beats served from a
// one-cycle-latency memory through a fall-through 2-entry buffer.
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [31:0]       s_araddr,
    input  logic [7:0]        s_arlen,
    input  AxiSize_t          s_arsize,
    input  AxiBurst_t         s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output AxiResp_t          s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LSB = $clog2(DATA_W / 8);
    localparam int BW  = DATA_W + 3;
    localparam logic [2:0] MAX_SIZE = 3'(LSB);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t      r_state;
    AxiAr_t      r_ar;
    AxiResp_t    r_err;
    logic [31:0] r_addr;
    logic [8:0]  r_issued;
    logic        r_infl;
    logic        r_infl_last;
    logic        r_arready;

    AxiResp_t          w_ar_err;
    logic [31:0]       w_addr;
    logic [DATA_W-1:0] w_rd;
    logic [BW-1:0]     w_in;
    logic [BW-1:0]     w_head;
    logic [BW-1:0]     w_out;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic              w_buf_nz;
    logic              w_pop;
    logic              w_buf_pop;
    logic              w_push;
    logic              w_issue;

    always_comb begin
        w_ar_err = RESP_OKAY;
        if (s_arsize > MAX_SIZE || s_arburst == BURST_RSVD ||
            (s_arburst == BURST_WRAP && !axiWrapLenLegal(s_arlen))) begin
            w_ar_err = RESP_SLVERR;
        end else if ((s_araddr >> (MEM_AW + LSB)) != 32'd0) begin
            w_ar_err = RESP_DECERR;
        end
    end

    // Beat 0 comes straight from the captured AR, later beats from r_addr
    assign w_addr = (r_issued == 9'd0) ? r_ar.addr : r_addr;

    // Data returning this cycle bypasses the buffer when it is empty
    assign w_rd     = (r_err == RESP_OKAY) ? mem_rdata : '0;
    assign w_in     = r_infl ? {w_rd, r_err, r_infl_last} : '0;
    assign w_buf_nz = (w_count != 2'd0);
    assign w_out    = w_buf_nz ? w_head : w_in;

    assign s_rvalid  = w_buf_nz | r_infl;
    assign s_rdata   = w_out[BW-1:3];
    assign s_rresp   = AxiResp_t'(w_out[2:1]);
    assign s_rlast   = w_out[0];
    assign s_rid     = ID_W'(r_ar.id);
    assign s_arready = r_arready;

    assign w_pop     = s_rvalid & s_rready;
    assign w_buf_pop = w_pop & w_buf_nz;
    assign w_push    = r_infl & ~(w_pop & ~w_buf_nz);

    assign w_occ   = {1'b0, w_count} + {2'b0, r_infl};
    assign w_issue = (r_state == ST_BURST) &&
                     (r_issued <= {1'b0, r_ar.len}) &&
                     (w_occ < (3'd2 + {2'b0, w_pop}));

    assign mem_en   = w_issue && (r_err == RESP_OKAY);
    assign mem_addr = w_addr[MEM_AW+LSB-1:LSB];

    axi_rd_buf #(
        .W (BW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_in),
        .i_pop   (w_buf_pop),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ar        <= '0;
            r_err       <= RESP_OKAY;
            r_addr      <= '0;
            r_issued    <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_arready   <= 1'b0;
        end else begin
            r_infl      <= w_issue;
            r_infl_last <= w_issue && (r_issued == {1'b0, r_ar.len});
            unique case (r_state)
                ST_IDLE: begin
                    r_arready <= 1'b1;
                    if (s_arvalid && r_arready) begin
                        r_ar <= '{id:    16'(s_arid),
                                  addr:  s_araddr,
                                  len:   s_arlen,
                                  size:  s_arsize,
                                  burst: s_arburst};
                        r_err     <= w_ar_err;
                        r_issued  <= '0;
                        r_arready <= 1'b0;
                        r_state   <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_issue) begin
                        r_addr   <= axiNextAddr(w_addr, r_ar.size,
                                                r_ar.burst, r_ar.len);
                        r_issued <= r_issued + 9'd1;
                    end
                    if (w_pop && s_rlast) begin
                        r_state   <= ST_IDLE;
                        r_arready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
